// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// - RESET_PC / NOP_INSTR : architectural reset address and bubble instruction
// - fsm_state_e          : BOOT/RUN state encoding for the fetch FSM
// - pc_op_e              : control encoding for the pc_register sub-module
// - ifid_t               : packed IF/ID pipeline register contents
// Optional feature: FETCH_PERF_CNT_EN (handled in fetch_stage.sv).
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // A bubble is a NOP with no return address and the valid bit clear.
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
// - imem_req   : fetch request (fetch side drives)
// - imem_addr  : byte address of the requested word, equal to the PC
// - imem_ready : imem_rdata is valid this cycle (memory side drives)
// - imem_rdata : fetched instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter register for the fetch stage.
// - clk, reset : clock and asynchronous active-high reset (PC <= RESET_PC)
// - op         : PC_HOLD keeps the value, PC_LOAD takes target, PC_INC adds 4
// - target     : redirect destination; bits [1:0] are forced to 00 on load
// - pc         : current program counter
module pc_register
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  pc_op_e      op,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      case (op)
        PC_LOAD: pc <= {target[31:2], 2'b00};
        PC_INC:  pc <= pc + PC_STEP; // wraps FFFF_FFFC -> 0 by width
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, BOOT/RUN FSM and the IF/ID register.
// - clk, reset         : clock and asynchronous active-high reset
// - stall              : freeze PC and IF/ID (ignores redirects that cycle)
// - branch_taken/target: redirect from a taken branch resolved in ID
// - jump/jump_target   : redirect from j/jal decoded in ID (wins over branch)
// - imem               : instruction memory bus (fetch_stage_if.master)
// - ifid_instr/pc_plus4/valid : IF/ID register contents
// - ifid_rs/ifid_rt    : source register fields of ifid_instr for hazard logic
// - stall_cycles/bubble_cycles : saturating performance counters, present only
//   when the macro FETCH_PERF_CNT_EN is defined
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  fetch_stage_if.master imem,
  output logic [31:0]   ifid_instr,
  output logic [31:0]   ifid_pc_plus4,
  output logic          ifid_valid,
  output logic [4:0]    ifid_rs,
  output logic [4:0]    ifid_rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   bubble_cycles
`endif
);

  fsm_state_e  state;
  logic        req_q;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        load_bubble;
  logic        load_fetch;
  pc_op_e      pc_op;
  ifid_t       ifid_q;

  // FSM: BOOT lasts exactly one clock after reset, then RUN until the next
  // reset. imem_req is a registered output that follows the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      req_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          req_q <= 1'b1;
        end
        default: begin
          state <= RUN;
          req_q <= 1'b1;
        end
      endcase
    end
  end

  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;
  assign pc_plus4        = pc + PC_STEP;

  // Per-cycle priority in RUN: stall, then redirect, then fetch.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_op       = PC_HOLD;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;
    if (state == BOOT) begin
      load_bubble = 1'b1;
    end else if (!stall) begin
      if (redirect) begin
        pc_op       = PC_LOAD;
        load_bubble = 1'b1;
      end else if (imem.imem_ready) begin
        pc_op      = PC_INC;
        load_fetch = 1'b1;
      end else begin
        load_bubble = 1'b1;
      end
    end
  end

  pc_register u_pc_register (
    .clk    (clk),
    .reset  (reset),
    .op     (pc_op),
    .target (redirect_target),
    .pc     (pc)
  );

  // IF/ID register: neither load flag set means hold (stall in RUN).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= IFID_BUBBLE;
    end else if (load_bubble) begin
      ifid_q <= IFID_BUBBLE;
    end else if (load_fetch) begin
      ifid_q <= '{instr: imem.imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc_plus4  = ifid_q.pc_plus4;
  assign ifid_valid     = ifid_q.valid;
  assign ifid_rs        = ifid_q.instr[25:21];
  assign ifid_rt        = ifid_q.instr[20:16];

`ifdef FETCH_PERF_CNT_EN
  // Both counters only advance in RUN and stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= 32'h0;
      bubble_cycles <= 32'h0;
    end else if (state == RUN) begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (load_bubble && (bubble_cycles != 32'hFFFF_FFFF)) begin
        bubble_cycles <= bubble_cycles + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1, from hazard detection; freeze the PC and the IF/ID register.
REQ-004 SHALL have port branch_taken, input, 1, beq/bne resolved taken in ID; redirect to branch_target.
REQ-005 SHALL have port branch_target, input, 32, branch destination byte address.
REQ-006 SHALL have port jump, input, 1, j/jal decoded in ID; redirect to jump_target.
REQ-007 SHALL have port jump_target, input, 32, jump destination byte address.
REQ-008 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-009 SHALL have port imem_addr, output, 32, current PC.
REQ-010 SHALL have port imem_ready, input, 1, imem_rdata is valid this cycle.
REQ-011 SHALL have port imem_rdata, input, 32, fetched instruction.
REQ-012 SHALL have ports ifid_instr, ifid_pc_plus4, ifid_valid, outputs, 32/32/1, the IF/ID register contents.
REQ-013 SHALL have ports ifid_rs and ifid_rt, outputs, 5 each, equal to ifid_instr[25:21] and ifid_instr[20:16], feeding hazard detection.

Function
REQ-014 The FSM SHALL have two states: BOOT and RUN.
REQ-015 The FSM SHALL enter BOOT on reset, move to RUN after exactly one clock, and stay in RUN until the next reset.
REQ-016 In BOOT, imem_req SHALL be 0, the PC SHALL hold, and IF/ID SHALL load a bubble.
REQ-017 In RUN, imem_req SHALL be 1, and imem_addr SHALL equal the PC at all times.
REQ-018 A bubble SHALL mean ifid_instr=32'h0 (NOP), ifid_pc_plus4=0 and ifid_valid=0.
REQ-019 Per-cycle priority in RUN: stall, then redirect (jump over branch_taken), then fetch.
REQ-020 On stall=1, PC and IF/ID SHALL hold; any redirect input that cycle SHALL be ignored.
REQ-021 On a redirect with stall=0, PC SHALL load the target with bits [1:0] forced to 00, and IF/ID SHALL load a bubble, whatever imem_ready is.
REQ-022 On jump=1 together with branch_taken=1, jump_target SHALL win.
REQ-023 On a fetch with imem_ready=1, PC SHALL become PC+4 (modulo 2^32, FFFF_FFFC wraps to 0), and IF/ID SHALL load {imem_rdata, PC+4, valid=1}.
REQ-024 On a fetch with imem_ready=0, PC SHALL hold and IF/ID SHALL load a bubble.
REQ-025 Fetch latency SHALL be one cycle: an instruction accepted at edge N SHALL appear on ifid_* after edge N.

Reset
REQ-026 Reset SHALL act immediately, without waiting for clk.
REQ-027 On reset: PC=RESET_PC (32'h0000_0000), state=BOOT, IF/ID=bubble, imem_req=0, counters=0.
REQ-028 Reset asserted mid-fetch SHALL drop the fetch and SHALL NOT write any partial IF/ID value.

Configuration
REQ-029 SHALL use macro FETCH_PERF_CNT_EN.
REQ-030 With FETCH_PERF_CNT_EN defined, the block SHALL add outputs stall_cycles[31:0] and bubble_cycles[31:0].
REQ-031 stall_cycles SHALL count RUN cycles with stall=1; bubble_cycles SHALL count RUN cycles in which IF/ID loads a bubble.
REQ-032 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-033 Without FETCH_PERF_CNT_EN, neither port nor counter logic SHALL exist, and function SHALL otherwise be identical.

Structure
REQ-034 A shared package SHALL hold RESET_PC, NOP_INSTR (32'h0) and the BOOT/RUN state encoding.
REQ-035 The PC update SHALL be a sub-module pc_register: 32-bit register with hold, load-target and increment controls.
REQ-036 The IF/ID register, FSM and counters SHALL live in fetch_stage.

Verification
REQ-037 Reset then imem_ready=1 with sequential words: imem_addr 0,0,4,8; ifid_pc_plus4 4 then 8; first ifid_valid=1 two edges after reset release.
REQ-038 stall=1 for 3 cycles at PC=0x10: imem_addr stays 0x10; ifid_* unchanged; stall_cycles +3 with FETCH_PERF_CNT_EN.
REQ-039 branch_taken=1 with branch_target=0x41 at PC=0x20: next imem_addr=0x40; ifid_valid=0 for one cycle; the instruction at 0x40 reaches IF/ID on the following edge.
REQ-040 jump=1 (target 0x100) and branch_taken=1 (target 0x200) with stall=1: no redirect; same inputs with stall=0: PC=0x100.
REQ-041 imem_ready=0 for 2 cycles: PC holds, two bubbles, bubble_cycles +2; PC=0xFFFF_FFFC with ready=1 wraps to 0.
REQ-042 reset pulsed asynchronously between edges mid-run: outputs take reset values before the next edge; the sequence restarts at BOOT.
